// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan driver: segment byte type, the "all dark"
// pattern and the active-low hex glyph table indexed by nibble (bit order {g,f,e,d,c,b,a}).
package display_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/display_7_seg_scan_if.sv
// Display-side bundle: status inputs from the core and the registered pin outputs.
interface display_7_seg_scan_if
    import display_pkg::*;
#(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] value;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [3:0]            bright;
    seg_t                  seg;
    logic [N_DIGITS-1:0]   digit;
    logic                  frame;

    modport master (
        output value, dp, blank, bright,
        input  seg, digit, frame
    );

    modport slave (
        input  value, dp, blank, bright,
        output seg, digit, frame
    );
endinterface

// File: rtl/display_7_seg_scan_hex_to_seg_lut.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_seg_lut
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);
    assign seg_n = HEX_SEG_TABLE[nibble];
endmodule

// File: rtl/display_7_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness and frame snapshots.
// Optional leading-zero blanking is enabled by defining DISPLAY_7_SEG_LZB_EN.
module display_7_seg_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int PRESCALE_W = 12
)(
    input logic                 CLK,
    input logic                 RST,
    display_7_seg_scan_if.slave bus
);
    localparam int CUR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CUR_W-1:0] LAST = CUR_W'(N_DIGITS - 1);

    logic [PRESCALE_W-1:0] cnt;
    logic [CUR_W-1:0]      cur;
    logic [3:0]            snib [N_DIGITS];
    logic [N_DIGITS-1:0]   sdp;
    logic [N_DIGITS-1:0]   sblank;
    logic [N_DIGITS-1:0]   slzb;
    logic [N_DIGITS-1:0]   lzb_next;
    logic                  tick;
    logic                  frame_tick;
    logic [3:0]            level;
    logic                  on;
    logic [6:0]            glyph_n;
    seg_t                  seg_q;
    logic [N_DIGITS-1:0]   digit_q;
    logic                  frame_q;

    assign tick       = &cnt;
    assign frame_tick = tick && (cur == LAST);
    assign level      = cnt[PRESCALE_W-1 -: 4];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            cur <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
            if (tick)
                cur <= (cur == LAST) ? '0 : cur + CUR_W'(1);
        end
    end

`ifdef DISPLAY_7_SEG_LZB_EN
    logic seen_nonzero;

    // Digit 0 is never hidden; higher digits hide until a non-zero nibble is seen from the top.
    always_comb begin
        lzb_next     = '0;
        seen_nonzero = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            seen_nonzero = seen_nonzero | (bus.value[4*i +: 4] != 4'h0);
            lzb_next[i]  = !seen_nonzero;
        end
    end
`else
    assign lzb_next = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_DIGITS; i++)
                snib[i] <= 4'h0;
            sdp    <= '0;
            sblank <= '0;
            slzb   <= '0;
        end else if (frame_tick) begin
            for (int i = 0; i < N_DIGITS; i++)
                snib[i] <= bus.value[4*i +: 4];
            sdp    <= bus.dp;
            sblank <= bus.blank;
            slzb   <= lzb_next;
        end
    end

    hex_to_seg_lut u_lut (
        .nibble (snib[cur]),
        .seg_n  (glyph_n)
    );

    assign on = (level <= bus.bright) && !sblank[cur] && !slzb[cur];

    // The last cycle of each slot (tick) keeps the anodes off so the next digit never ghosts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_q   <= SEG_OFF;
            digit_q <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= on ? {~sdp[cur], glyph_n} : SEG_OFF;
            digit_q <= (on && !tick) ? ~(N_DIGITS'(1) << cur) : '1;
            frame_q <= frame_tick;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.digit = digit_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_display_7_seg_scan.sv
// Bench for display_7_seg_scan (3 digits, 16-cycle slots): cycle-indexed reference model
// plus directed scan/coherence/brightness/blank/reset scenarios and random traffic.
module tb_display_7_seg_scan;
    localparam int N    = 3;
    localparam int SLOT = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    display_7_seg_scan_if #(.N_DIGITS(N)) bus ();

    display_7_seg_scan #(.N_DIGITS(N), .PRESCALE_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Lit segments per hex digit, active-high, bit0 = a ... bit6 = g.
    logic [6:0] seg_on [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int         lit_cnt [N];
    logic [7:0] seg_mid [N];
    logic [2:0] dig_mid [N];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] lzb_dark(input logic [11:0] v);
        logic [2:0] d = '0;
`ifdef DISPLAY_7_SEG_LZB_EN
        int h = 0;
        for (int i = 0; i < N; i++)
            if (4'(v >> (4*i)) != 4'h0) h = i;
        for (int i = 1; i < N; i++)
            d[i] = (i > h);
`endif
        return d;
    endfunction

    // Reference: k counts clock edges since reset release; slot and phase follow from k directly.
    initial begin
        int         k;
        int         phase;
        int         slot;
        logic [11:0] m_value;
        logic [2:0]  m_dp;
        logic [2:0]  m_blank;
        logic [2:0]  dark;
        logic [3:0]  nib;
        logic        shown;
        logic [7:0]  e_seg;
        logic [2:0]  e_dig;
        logic        e_frame;
        k = 0;
        m_value = '0;
        m_dp = '0;
        m_blank = '0;
        forever begin
            @(posedge CLK);
            if (RST) begin
                k = 0;
                m_value = '0;
                m_dp = '0;
                m_blank = '0;
                e_seg = 8'hFF;
                e_dig = 3'b111;
                e_frame = 1'b0;
            end else begin
                phase = k % SLOT;
                slot  = (k / SLOT) % N;
                dark  = m_blank | lzb_dark(m_value);
                nib   = 4'(m_value >> (4*slot));
                shown = (phase <= int'(bus.bright)) && !dark[slot];
                e_seg   = shown ? {~m_dp[slot], ~seg_on[nib]} : 8'hFF;
                e_dig   = (shown && phase != SLOT - 1) ? ~(3'b001 << slot) : 3'b111;
                e_frame = (k % (N*SLOT)) == (N*SLOT - 1);
                if (e_frame) begin
                    m_value = bus.value;
                    m_dp    = bus.dp;
                    m_blank = bus.blank;
                end
                k++;
            end
            #1;
            checkOutput("model_seg", {24'h0, bus.seg}, {24'h0, e_seg});
            checkOutput("model_digit", {29'h0, bus.digit}, {29'h0, e_dig});
            checkOutput("model_frame", {31'h0, bus.frame}, {31'h0, e_frame});
        end
    end

    task automatic applyStimulus(input logic [11:0] v, input logic [2:0] d, input logic [2:0] b,
                                 input logic [3:0] br);
        @(negedge CLK);
        bus.value  = v;
        bus.dp     = d;
        bus.blank  = b;
        bus.bright = br;
    endtask

    task automatic waitFrame();
        logic found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (bus.frame) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("frame_seen", {31'h0, found}, 32'h1);
    endtask

    // Called right after a frame pulse; the following negedges show slot 0 phase 0 onward.
    task automatic scanFrame();
        for (int s = 0; s < N; s++) lit_cnt[s] = 0;
        for (int j = 0; j < N*SLOT; j++) begin
            @(negedge CLK);
            if (bus.digit != 3'b111) lit_cnt[j / SLOT]++;
            if (j % SLOT == 5) begin
                seg_mid[j / SLOT] = bus.seg;
                dig_mid[j / SLOT] = bus.digit;
            end
        end
    endtask

    initial begin
        bus.value  = '0;
        bus.dp     = '0;
        bus.blank  = '0;
        bus.bright = 4'hF;
        repeat (3) @(negedge CLK);
        checkOutput("reset_seg", {24'h0, bus.seg}, 32'hFF);
        checkOutput("reset_digit", {29'h0, bus.digit}, 32'h7);
        checkOutput("reset_frame", {31'h0, bus.frame}, 32'h0);
        RST = 1'b0;

        applyStimulus(12'h1A7, 3'b000, 3'b000, 4'hF);
        waitFrame();
        scanFrame();
        checkOutput("scan_dig0", {29'h0, dig_mid[0]}, 32'h6);
        checkOutput("scan_dig1", {29'h0, dig_mid[1]}, 32'h5);
        checkOutput("scan_dig2", {29'h0, dig_mid[2]}, 32'h3);
        checkOutput("scan_seg0", {24'h0, seg_mid[0]}, 32'hF8);
        checkOutput("scan_seg1", {24'h0, seg_mid[1]}, 32'h88);
        checkOutput("scan_seg2", {24'h0, seg_mid[2]}, 32'hF9);
        checkOutput("bright15_lit", lit_cnt[0], 32'd15);

        repeat (20) @(negedge CLK);
        applyStimulus(12'h2B8, 3'b000, 3'b000, 4'hF);
        repeat (17) @(negedge CLK);
        checkOutput("coherent_old", {24'h0, bus.seg}, 32'hF9);
        waitFrame();
        scanFrame();
        checkOutput("coherent_new0", {24'h0, seg_mid[0]}, 32'h80);
        checkOutput("coherent_new1", {24'h0, seg_mid[1]}, 32'h83);
        checkOutput("coherent_new2", {24'h0, seg_mid[2]}, 32'hA4);

        applyStimulus(12'h1A7, 3'b000, 3'b000, 4'h0);
        waitFrame();
        scanFrame();
        checkOutput("bright0_lit", lit_cnt[0], 32'd1);
        applyStimulus(12'h1A7, 3'b000, 3'b000, 4'h7);
        waitFrame();
        scanFrame();
        checkOutput("bright7_lit", lit_cnt[1], 32'd8);

        applyStimulus(12'h1A7, 3'b001, 3'b010, 4'hF);
        waitFrame();
        scanFrame();
        checkOutput("blank_dig1", lit_cnt[1], 32'd0);
        checkOutput("dp_dig0", {24'h0, seg_mid[0]}, 32'h78);

        applyStimulus(12'h005, 3'b000, 3'b000, 4'hF);
        waitFrame();
        scanFrame();
`ifdef DISPLAY_7_SEG_LZB_EN
        checkOutput("lzb5_dig0", lit_cnt[0], 32'd15);
        checkOutput("lzb5_dig1", lit_cnt[1], 32'd0);
        checkOutput("lzb5_dig2", lit_cnt[2], 32'd0);
        applyStimulus(12'h000, 3'b000, 3'b000, 4'hF);
        waitFrame();
        scanFrame();
        checkOutput("lzb0_seg0", {24'h0, seg_mid[0]}, 32'hC0);
        checkOutput("lzb0_dig2", lit_cnt[2], 32'd0);
`else
        checkOutput("nolzb_dig2", lit_cnt[2], 32'd15);
        checkOutput("nolzb_seg2", {24'h0, seg_mid[2]}, 32'hC0);
`endif

        repeat (7) @(negedge CLK);
        RST = 1'b1;
        #1;
        checkOutput("async_seg", {24'h0, bus.seg}, 32'hFF);
        checkOutput("async_digit", {29'h0, bus.digit}, 32'h7);
        checkOutput("async_frame", {31'h0, bus.frame}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("restart_digit", {29'h0, bus.digit}, 32'h6);
        checkOutput("restart_seg", {24'h0, bus.seg}, 32'hC0);

        for (int it = 0; it < 25; it++) begin
            applyStimulus(12'($urandom), 3'($urandom), 3'($urandom), 4'($urandom));
            repeat ($urandom_range(1, 60)) @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
